// File: rtl/irq_sequencer.sv
// rtl/irq_sequencer.sv - interrupt flag/enable registers, IME control and vector dispatch sequencer (option: IRQ_CANCEL_EN)
module irq_sequencer (
  input  logic       CLK,
  input  logic       RES,
  input  logic [4:0] IRQ_TRIG,
  input  logic [7:0] DIN,
  input  logic       IE_WE,
  input  logic       IF_WE,
  output logic [7:0] IE_Q,
  output logic [7:0] IF_Q,
  input  logic       EI_REQ,
  input  logic       DI_REQ,
  input  logic       RETI_REQ,
  input  logic       INSTR_END,
  output logic       IME_Q,
  output logic       WAKE,
  output logic       INT_PEND,
  input  logic       INT_TAKE,
  input  logic       VEC_SAMPLE,
  output logic [7:0] VEC,
  output logic [7:0] CPU_IRQ_ACK
);

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DISPATCH = 2'd1;
  localparam logic [1:0] ST_ACK      = 2'd2;

  logic [7:0] ie_r;
  logic [4:0] if_r;
  logic       ime_r;
  logic       ei_armed;
  logic [1:0] state;
  logic [7:0] vec_r;
  logic [4:0] ack_r;

  logic [4:0] pending;
  logic [2:0] sel_idx;
  logic       sel_valid;
  logic [2:0] use_idx;
  logic       use_valid;
  logic       take;
  logic       fire;
  logic [4:0] use_mask;
  logic [4:0] if_next;

  // Requests that are both flagged and enabled; lowest index wins
  always_comb begin
    pending   = ie_r[4:0] & if_r;
    sel_idx   = 3'd0;
    sel_valid = 1'b0;
    for (int i = 4; i >= 0; i--) begin
      if (pending[i]) begin
        sel_idx   = 3'(i);
        sel_valid = 1'b1;
      end
    end
  end

  assign WAKE     = |pending;
  assign INT_PEND = ime_r & WAKE & (state == ST_IDLE);
  assign take     = (state == ST_IDLE) & INT_TAKE & INT_PEND;
  assign fire     = (state == ST_DISPATCH) & VEC_SAMPLE;

`ifdef IRQ_CANCEL_EN
  // Priority is resolved late, so a vanished request cancels the dispatch
  always_comb begin
    use_idx   = sel_idx;
    use_valid = sel_valid;
  end
`else
  logic [2:0] idx_lat;

  // Index frozen at dispatch start; later IE/IF changes cannot redirect it
  always_ff @(posedge CLK or posedge RES) begin
    if (RES)       idx_lat <= 3'd0;
    else if (take) idx_lat <= sel_idx;
  end

  // Latched index is always a real source
  always_comb begin
    use_idx   = idx_lat;
    use_valid = 1'b1;
  end
`endif

  assign use_mask = use_valid ? (5'b00001 << use_idx) : 5'b00000;

  // IF update: write or acknowledge clear, with live requests always winning
  always_comb begin
    if_next = if_r;
    if (IF_WE)     if_next = DIN[4:0];
    else if (fire) if_next = if_r & ~use_mask;
    if_next = if_next | IRQ_TRIG;
  end

  // Flag and enable registers
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      ie_r <= 8'h00;
      if_r <= 5'h00;
    end else begin
      if (IE_WE) ie_r <= DIN;
      if_r <= if_next;
    end
  end

  // Master enable and delayed-EI tracking; DI and dispatch start take precedence
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      ime_r    <= 1'b0;
      ei_armed <= 1'b0;
    end else if (DI_REQ || take) begin
      ime_r    <= 1'b0;
      ei_armed <= 1'b0;
    end else begin
      if (RETI_REQ || (ei_armed && INSTR_END)) ime_r <= 1'b1;
      ei_armed <= EI_REQ | (ei_armed & ~INSTR_END);
    end
  end

  // Dispatch FSM with vector resolve and one-cycle acknowledge pulse
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      state <= ST_IDLE;
      vec_r <= 8'h00;
      ack_r <= 5'h00;
    end else begin
      case (state)
        ST_IDLE: begin
          ack_r <= 5'h00;
          if (take) state <= ST_DISPATCH;
        end
        ST_DISPATCH: begin
          if (fire) begin
            state <= ST_ACK;
            vec_r <= use_valid ? (8'h40 + {2'b00, use_idx, 3'b000}) : 8'h00;
            ack_r <= use_mask;
          end
        end
        ST_ACK: begin
          state <= ST_IDLE;
          ack_r <= 5'h00;
        end
        default: begin
          state <= ST_IDLE;
          ack_r <= 5'h00;
        end
      endcase
    end
  end

  assign IE_Q        = ie_r;
  assign IF_Q        = {3'b111, if_r};
  assign IME_Q       = ime_r;
  assign VEC         = vec_r;
  assign CPU_IRQ_ACK = {3'b000, ack_r};

endmodule

// File: tb/tb_irq_sequencer.sv
// tb/tb_irq_sequencer.sv - directed self-checking bench for irq_sequencer with dispatch scoreboard
module tb_irq_sequencer;

  logic       CLK = 1'b0;
  logic       RES = 1'b1;
  logic [4:0] IRQ_TRIG = '0;
  logic [7:0] DIN = '0;
  logic       IE_WE = 0, IF_WE = 0;
  logic [7:0] IE_Q, IF_Q;
  logic       EI_REQ = 0, DI_REQ = 0, RETI_REQ = 0, INSTR_END = 0;
  logic       IME_Q, WAKE, INT_PEND;
  logic       INT_TAKE = 0, VEC_SAMPLE = 0;
  logic [7:0] VEC, CPU_IRQ_ACK;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0] vec;
    logic [7:0] ack;
    logic [7:0] ifq;
  } disp_t;

  disp_t sb[$];

  irq_sequencer dut (
    .CLK(CLK), .RES(RES), .IRQ_TRIG(IRQ_TRIG), .DIN(DIN),
    .IE_WE(IE_WE), .IF_WE(IF_WE), .IE_Q(IE_Q), .IF_Q(IF_Q),
    .EI_REQ(EI_REQ), .DI_REQ(DI_REQ), .RETI_REQ(RETI_REQ), .INSTR_END(INSTR_END),
    .IME_Q(IME_Q), .WAKE(WAKE), .INT_PEND(INT_PEND),
    .INT_TAKE(INT_TAKE), .VEC_SAMPLE(VEC_SAMPLE), .VEC(VEC), .CPU_IRQ_ACK(CPU_IRQ_ACK)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: inputs set before the call take effect at the edge; strobes then drop
  task automatic tick();
    @(posedge CLK);
    #1;
    IE_WE = 0; IF_WE = 0; EI_REQ = 0; DI_REQ = 0; RETI_REQ = 0;
    INSTR_END = 0; INT_TAKE = 0; VEC_SAMPLE = 0; IRQ_TRIG = '0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_ie"},   IE_Q, 8'h00);
    chk({tag, "_if"},   IF_Q, 8'hE0);
    chk({tag, "_ime"},  {7'd0, IME_Q}, 8'h00);
    chk({tag, "_wake"}, {7'd0, WAKE}, 8'h00);
    chk({tag, "_pend"}, {7'd0, INT_PEND}, 8'h00);
    chk({tag, "_vec"},  VEC, 8'h00);
    chk({tag, "_ack"},  CPU_IRQ_ACK, 8'h00);
  endtask

  // Pops the oldest expectation and compares it with the resolved dispatch
  task automatic check_dispatch(input string tag);
    disp_t e;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s_sb observed empty expected entry", tag);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk({tag, "_vec"}, VEC, e.vec);
      chk({tag, "_ack"}, CPU_IRQ_ACK, e.ack);
      chk({tag, "_if"},  IF_Q, e.ifq);
    end
  endtask

  initial begin
    #2;
    check_reset_outputs("rst");
    @(negedge CLK);
    RES = 0;
    tick();

    // Timer interrupt after EI with one-instruction delay
    IE_WE = 1; DIN = 8'h05; tick();
    IRQ_TRIG = 5'b00100; tick();
    chk("t1_if", IF_Q, 8'hE4);
    chk("t1_wake", {7'd0, WAKE}, 8'h01);
    chk("t1_pend0", {7'd0, INT_PEND}, 8'h00);
    EI_REQ = 1; INSTR_END = 1; tick();
    chk("t1_ime_same", {7'd0, IME_Q}, 8'h00);
    INSTR_END = 1; tick();
    chk("t1_ime", {7'd0, IME_Q}, 8'h01);
    chk("t1_pend", {7'd0, INT_PEND}, 8'h01);
    INT_TAKE = 1; sb.push_back('{vec: 8'h50, ack: 8'h04, ifq: 8'hE0}); tick();
    chk("t1_ime_take", {7'd0, IME_Q}, 8'h00);
    chk("t1_pend_take", {7'd0, INT_PEND}, 8'h00);
    VEC_SAMPLE = 1; tick();
    check_dispatch("t1");
    tick();
    chk("t1_ack_end", CPU_IRQ_ACK, 8'h00);
    chk("t1_vec_hold", VEC, 8'h50);

    // Priority: VBlank first, then STAT after RETI
    IE_WE = 1; DIN = 8'h1F; tick();
    IF_WE = 1; DIN = 8'h13; tick();
    RETI_REQ = 1; tick();
    chk("t2_ime", {7'd0, IME_Q}, 8'h01);
    INT_TAKE = 1; sb.push_back('{vec: 8'h40, ack: 8'h01, ifq: 8'hF2}); tick();
    VEC_SAMPLE = 1; tick();
    check_dispatch("t2a");
    tick();
    RETI_REQ = 1; tick();
    INT_TAKE = 1; sb.push_back('{vec: 8'h48, ack: 8'h02, ifq: 8'hF0}); tick();
    VEC_SAMPLE = 1; tick();
    check_dispatch("t2b");
    tick();

    // EI and DI together: DI wins, EI not armed
    EI_REQ = 1; DI_REQ = 1; tick();
    INSTR_END = 1; tick();
    chk("t3_ime", {7'd0, IME_Q}, 8'h00);
    chk("t3_pend", {7'd0, INT_PEND}, 8'h00);
    chk("t3_wake", {7'd0, WAKE}, 8'h01);
    INT_TAKE = 1; tick();
    VEC_SAMPLE = 1; tick();
    chk("t3_ignored_ack", CPU_IRQ_ACK, 8'h00);
    chk("t3_ignored_vec", VEC, 8'h48);

    // IE cleared between dispatch start and vector resolve
    IF_WE = 1; DIN = 8'h00; tick();
    IE_WE = 1; DIN = 8'h01; tick();
    IF_WE = 1; DIN = 8'h01; tick();
    RETI_REQ = 1; tick();
`ifdef IRQ_CANCEL_EN
    sb.push_back('{vec: 8'h00, ack: 8'h00, ifq: 8'hE1});
`else
    sb.push_back('{vec: 8'h40, ack: 8'h01, ifq: 8'hE0});
`endif
    INT_TAKE = 1; tick();
    IE_WE = 1; DIN = 8'h00; tick();
    VEC_SAMPLE = 1; tick();
    check_dispatch("t4");
    tick();

    // Live request beats a simultaneous write of zero
    IF_WE = 1; DIN = 8'h00; IRQ_TRIG = 5'b00001; tick();
    chk("t5_if_trig_wins", IF_Q, 8'hE1);

    // Reset mid-dispatch aborts without an acknowledge
    IE_WE = 1; DIN = 8'h01; tick();
    RETI_REQ = 1; tick();
    chk("t6_pend", {7'd0, INT_PEND}, 8'h01);
    INT_TAKE = 1; tick();
    #2;
    RES = 1;
    #1;
    check_reset_outputs("t6_async");
    tick();
    RES = 0;
    VEC_SAMPLE = 1; tick();
    chk("t6_ack", CPU_IRQ_ACK, 8'h00);
    chk("t6_vec", VEC, 8'h00);
    chk("t6_if", IF_Q, 8'hE0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/irq_sequencer.md
IRQ_SEQUENCER -- requirements
Module: irq_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1 bit: the single block clock; all state updates on its rising edge.
REQ-002 SHALL have port RES, input, 1 bit: reset, asynchronous, active-high.
REQ-003 SHALL have port IRQ_TRIG, input, 5 bits: level interrupt requests, bit0 VBlank, bit1 STAT, bit2 Timer, bit3 Serial, bit4 Joypad.
REQ-004 SHALL have port DIN, input, 8 bits: register write data.
REQ-005 SHALL have port IE_WE / IF_WE, inputs, 1 bit each: one-cycle write strobes for IE (FFFF) and IF (FF0F).
REQ-006 SHALL have port IE_Q, output, 8 bits: IE register contents.
REQ-007 SHALL have port IF_Q, output, 8 bits: {3'b111, IF[4:0]}.
REQ-008 SHALL have ports EI_REQ, DI_REQ, RETI_REQ, INSTR_END, inputs, 1 bit each: decoder strobes and end-of-instruction strobe.
REQ-009 SHALL have port IME_Q, output, 1 bit: master enable.
REQ-010 SHALL have port WAKE, output, 1 bit: HALT/STOP wake, |(IE[4:0] & IF[4:0]), independent of IME.
REQ-011 SHALL have port INT_PEND, output, 1 bit: dispatch request to sequencer.
REQ-012 SHALL have ports INT_TAKE and VEC_SAMPLE, inputs, 1 bit each: dispatch start strobe; vector-resolve strobe (after PC high byte pushed).
REQ-013 SHALL have port VEC, output, 8 bits: low byte of dispatch address.
REQ-014 SHALL have port CPU_IRQ_ACK, output, 8 bits: one-hot acknowledge pulse, bits [7:5] always 0.

Function
REQ-015 SHALL set IF[i] at every edge where IRQ_TRIG[i]=1; IF_WE loads DIN[4:0] OR IRQ_TRIG (request wins over simultaneous write of 0).
REQ-016 SHALL load IE from DIN on IE_WE, all 8 bits stored.
REQ-017 SHALL clear IME on the edge DI_REQ is seen, and also cancel any armed EI.
REQ-018 SHALL arm EI on EI_REQ; armed EI sets IME on the first INSTR_END strictly after the EI_REQ cycle (one-instruction delay); EI_REQ and INSTR_END in the same cycle does not set IME.
REQ-019 SHALL set IME on RETI_REQ at the next edge, no delay; DI_REQ simultaneous with EI_REQ or RETI_REQ: DI wins.
REQ-020 SHALL drive INT_PEND = IME & WAKE & (state==IDLE), combinational.
REQ-021 SHALL implement FSM IDLE -> DISPATCH -> ACK -> IDLE.
REQ-022 IDLE->DISPATCH on INT_TAKE while INT_PEND=1; IME and armed EI cleared on the same edge; INT_TAKE with INT_PEND=0 ignored.
REQ-023 DISPATCH->ACK on VEC_SAMPLE; selected index i = lowest set bit of IE[4:0]&IF[4:0] resolved in that cycle (bit0 highest priority).
REQ-024 On that edge: VEC = 8'h40 + 8*i, IF[i] cleared (unless IRQ_TRIG[i] high same cycle, which wins), CPU_IRQ_ACK[i]=1 for exactly one cycle during ACK.
REQ-025 ACK->IDLE unconditionally next edge; CPU_IRQ_ACK returns to 0; VEC holds until next VEC_SAMPLE.
REQ-026 IF/IE writes SHALL remain effective in every state; WAKE tracks them combinationally.

Reset
REQ-027 RES=1 SHALL immediately force IE=0, IF=0, IME=0, EI unarmed, state IDLE, VEC=8'h00, CPU_IRQ_ACK=0; outputs therefore IE_Q=8'h00, IF_Q=8'hE0, IME_Q=0, WAKE=0, INT_PEND=0.
REQ-028 RES asserted during DISPATCH or ACK SHALL abort dispatch without ACK pulse or IF clear.

Configuration
REQ-029 Macro IRQ_CANCEL_EN defined: if IE[4:0]&IF[4:0]=0 at VEC_SAMPLE, VEC=8'h00, no IF clear, CPU_IRQ_ACK stays 0 (cancelled dispatch to 0000h); priority resolved at VEC_SAMPLE.
REQ-030 IRQ_CANCEL_EN undefined: index latched at INT_TAKE and used at VEC_SAMPLE regardless of later IE/IF changes; VEC never 8'h00 from dispatch.

Verification
REQ-031 Reset, IE=8'h05, IRQ_TRIG=5'b00100, EI_REQ then two INSTR_END -> IME_Q=1 after second, INT_PEND=1; INT_TAKE, VEC_SAMPLE -> VEC=8'h50, CPU_IRQ_ACK=8'h04 one cycle, IF_Q=8'hE0.
REQ-032 IF=5'b10011, IE=8'h1F, dispatch -> VEC=8'h40, IF_Q=8'hF2; second dispatch after RETI_REQ -> VEC=8'h48.
REQ-033 EI_REQ and DI_REQ same cycle, then INSTR_END -> IME_Q stays 0, INT_PEND=0 with WAKE=1.
REQ-034 With IRQ_CANCEL_EN: IE=8'h01, IF bit0, INT_TAKE, IE_WE DIN=8'h00 before VEC_SAMPLE -> VEC=8'h00, CPU_IRQ_ACK=0, IF_Q=8'hE1; without macro -> VEC=8'h40, ACK=8'h01.
REQ-035 RES pulsed between INT_TAKE and VEC_SAMPLE -> all outputs at reset values, no ACK pulse observed.
